// File: rtl/pipeline_pkg.sv
// Shared front-end definitions: fetch FSM encoding and reset/bubble defaults.
// The decode and execute stages import this package as well.
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2,
    S_DROP = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {instr, pcplus4} holding register for a fetch response that
// lands while decode is stalled.
module if_skid_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pcplus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pcplus4,
  output logic        o_full
);

  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic        r_full;

  // Clear beats load so a redirect always discards a same-cycle capture.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_full    <= 1'b0;
      r_instr   <= '0;
      r_pcplus4 <= '0;
    end else if (i_load) begin
      r_full    <= 1'b1;
      r_instr   <= i_instr;
      r_pcplus4 <= i_pcplus4;
    end
  end

  assign o_instr   = r_instr;
  assign o_pcplus4 = r_pcplus4;
  assign o_full    = r_full;

endmodule

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: PC register, one-outstanding-request fetch FSM,
// IF/ID pipeline register and a skid buffer for responses during a stall.
module pipeline_if
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        if_valid
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic        r_if_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_skid_instr;
  logic [31:0] w_skid_pcplus4;
  logic        w_skid_full;
  logic        w_skid_load;
  logic        w_skid_clear;
  logic        w_resp;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_resp       = (r_state == S_WAIT) && imem_valid;
  assign w_skid_load  = !redirect && w_resp && stall;
  assign w_skid_clear = redirect || ((r_state == S_HELD) && !stall);

  if_skid_buf u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_skid_load),
    .i_clear   (w_skid_clear),
    .i_instr   (imem_rdata),
    .i_pcplus4 (w_pc_plus4),
    .o_instr   (w_skid_instr),
    .o_pcplus4 (w_skid_pcplus4),
    .o_full    (w_skid_full)
  );

  // Gated by reset_n so no request escapes while reset is still asserted.
  assign imem_req  = reset_n && (r_state == S_REQ);
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pcplus4  <= '0;
      r_if_valid <= 1'b0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_instr    <= NOP_INSTR;
      r_if_valid <= 1'b0;
      // A request still in flight must have its response swallowed in DROP.
      r_state    <= ((r_state == S_WAIT || r_state == S_DROP) && !imem_valid) ? S_DROP : S_REQ;
    end else begin
      if (!stall) begin
        r_instr    <= NOP_INSTR;
        r_if_valid <= 1'b0;
      end
      case (r_state)
        S_REQ:  if (imem_ready) r_state <= S_WAIT;
        S_WAIT: if (imem_valid) begin
          r_pc <= w_pc_plus4;
          if (stall) begin
            r_state <= S_HELD;
          end else begin
            r_instr    <= imem_rdata;
            r_pcplus4  <= w_pc_plus4;
            r_if_valid <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_HELD: if (!stall) begin
          r_instr    <= w_skid_instr;
          r_pcplus4  <= w_skid_pcplus4;
          r_if_valid <= w_skid_full;
          r_state    <= S_REQ;
        end
        S_DROP: if (imem_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign instr    = r_instr;
  assign pcplus4  = r_pcplus4;
  assign if_valid = r_if_valid;

endmodule

// File: tb/tb_pipeline_if.sv
// Self-checking bench for pipeline_if: cycle vector table for the corner
// cases, then a randomly stalled stream checked against a scoreboard.
module tb_pipeline_if;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect, imem_ready, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, instr, pcplus4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_if dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pcplus4     (pcplus4),
    .if_valid    (if_valid)
  );

  // One record per clock cycle: inputs held over the cycle, expected
  // request/address during it, expected IF/ID after its rising edge.
  typedef struct {
    bit          rst_n, stl, rd;
    logic [31:0] rpc;
    bit          rdy, vld;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr, e_instr, e_pc4;
    bit          e_ifv;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  function automatic vec_t mk(bit rst_n, bit stl, bit rd, logic [31:0] rpc, bit rdy, bit vld,
                              logic [31:0] rdata, bit e_req, logic [31:0] e_addr,
                              logic [31:0] e_instr, logic [31:0] e_pc4, bit e_ifv);
    vec_t v;
    v.rst_n = rst_n; v.stl = stl; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.vld = vld;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pc4 = e_pc4; v.e_ifv = e_ifv;
    return v;
  endfunction

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic        pend, acc, drain;
    logic [31:0] pend_addr, acc_addr, exp_pc;
    exp_t        e;

    // reset, first fetch
    vq.push_back(mk(0,0,0,0,0,0,0,                 0,0,            0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,                 0,0,            0,0,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,0,            0,0,0));
    vq.push_back(mk(1,0,0,0,1,1,32'h2008_0005,     0,0,            32'h2008_0005,4,1));
    // response under a 3-cycle stall goes to the skid, then released
    vq.push_back(mk(1,1,0,0,1,0,0,                 1,4,            32'h2008_0005,4,1));
    vq.push_back(mk(1,1,0,0,0,1,32'hAAAA_0001,     0,0,            32'h2008_0005,4,1));
    vq.push_back(mk(1,1,0,0,1,0,0,                 0,0,            32'h2008_0005,4,1));
    vq.push_back(mk(1,1,0,0,1,0,0,                 0,0,            32'h2008_0005,4,1));
    vq.push_back(mk(1,0,0,0,1,0,0,                 0,0,            32'hAAAA_0001,8,1));
    // memory not ready for 5 cycles
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,0,0,0,0,0,               1,8,            0,8,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,8,            0,8,0));
    vq.push_back(mk(1,0,0,0,0,1,32'h0000_1111,     0,0,            32'h1111,32'hC,1));
    // redirect while waiting, stale word arrives 2 cycles later
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,32'hC,        0,32'hC,0));
    vq.push_back(mk(1,0,1,32'h40,0,0,0,            0,0,            0,32'hC,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 0,0,            0,32'hC,0));
    vq.push_back(mk(1,0,0,0,1,1,32'hDEAD_BEEF,     0,0,            0,32'hC,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,32'h40,       0,32'hC,0));
    vq.push_back(mk(1,0,0,0,0,1,32'h2222_0000,     0,0,            32'h2222_0000,32'h44,1));
    // redirect overrides stall; wrap at the top of the address space
    vq.push_back(mk(1,1,1,32'hFFFF_FFFC,0,0,0,     1,32'h44,       0,32'h44,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,32'hFFFF_FFFC,0,32'h44,0));
    vq.push_back(mk(1,0,0,0,0,1,32'h3333_0003,     0,0,            32'h3333_0003,0,1));
    vq.push_back(mk(1,0,0,0,0,0,0,                 1,0,            0,0,0));
    // redirect from HELD, redirect with response in the same cycle
    vq.push_back(mk(1,1,0,0,1,0,0,                 1,0,            0,0,0));
    vq.push_back(mk(1,1,0,0,0,1,32'h4444_0004,     0,0,            0,0,0));
    vq.push_back(mk(1,1,1,32'h100,0,0,0,           0,0,            0,0,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,32'h100,      0,0,0));
    vq.push_back(mk(1,0,1,32'h200,0,1,32'h5555_0005,0,0,           0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,                 1,32'h200,      0,0,0));
    // reset mid-stream, late response in REQ ignored
    vq.push_back(mk(0,0,0,0,0,0,0,                 0,0,            0,0,0));
    vq.push_back(mk(1,0,0,0,0,1,32'h6666_0006,     1,0,            0,0,0));
    vq.push_back(mk(1,0,0,0,1,0,0,                 1,0,            0,0,0));
    vq.push_back(mk(1,0,0,0,0,1,32'h7777_0007,     0,0,            32'h7777_0007,4,1));

    foreach (vq[i]) begin
      reset_n = vq[i].rst_n; stall = vq[i].stl; redirect = vq[i].rd;
      redirect_pc = vq[i].rpc; imem_ready = vq[i].rdy; imem_valid = vq[i].vld;
      imem_rdata = vq[i].rdata;
      #1;
      chk("req", i, {31'd0, imem_req}, {31'd0, vq[i].e_req});
      if (vq[i].e_req) chk("addr", i, imem_addr, vq[i].e_addr);
      @(posedge clk); #1;
      chk("instr", i, instr, vq[i].e_instr);
      chk("pcplus4", i, pcplus4, vq[i].e_pc4);
      chk("if_valid", i, {31'd0, if_valid}, {31'd0, vq[i].e_ifv});
    end

    // Streaming with random stall/ready and a 1-cycle memory.
    exp_pc = 32'h4; pend = 1'b0; pend_addr = '0;
    for (int c = 0; c < 330; c++) begin
      drain      = (c >= 300);
      redirect   = 1'b0;
      stall      = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
      imem_ready = drain ? 1'b0 : 1'($urandom_range(0, 1));
      imem_valid = pend;
      imem_rdata = pend ? word_of(pend_addr) : 32'h0;
      #1;
      if (imem_req) chk("stream_addr", c, imem_addr, exp_pc);
      if (pend) begin
        e.instr = word_of(pend_addr);
        e.pc4   = pend_addr + 32'd4;
        sb.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
      acc      = imem_req && imem_ready;
      acc_addr = imem_addr;
      @(posedge clk); #1;
      pend      = acc;
      pend_addr = acc_addr;
      if (!stall && if_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra[%0d]: got instr %h expected none", c, instr);
        end else begin
          e = sb.pop_front();
          chk("stream_instr", c, instr, e.instr);
          chk("stream_pc4", c, pcplus4, e.pc4);
        end
      end
    end
    chk("stream_left", 0, sb.size(), 0);
    chk("stream_count", 0, exp_pc > 32'h40 ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
